// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// program-memory byte address width used by the memory and program counter.
package prog_loader_pkg;

    localparam int unsigned PmAddWidth = 7;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StRun,
        StErr
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-serial program loader: streams bytes into consecutive program-memory
// addresses while holding the core in reset, then releases it on a whole-word load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADD_WIDTH  = PmAddWidth,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_mode,
    input  logic                  byte_valid,
    input  logic [DATA_WIDTH-1:0] byte_in,
    output logic                  byte_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wr_data,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADD_WIDTH:0]    bytes_loaded
);

    state_e state_q, state_d;

    logic [ADD_WIDTH:0]    count_q;
    logic                  wr_en_q;
    logic [ADD_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic full;
    logic accept;
    logic start_load;
    logic word_ok;

    // The MSB of the byte count is set exactly when all 2^ADD_WIDTH bytes are stored.
    assign full       = count_q[ADD_WIDTH];
    assign accept     = byte_valid & byte_ready;
    assign start_load = (state_q != StLoad) && (state_d == StLoad);
    assign word_ok    = (count_q[1:0] == 2'b00) && (count_q != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load_mode) state_d = StLoad;
            StLoad:  if (!load_mode) state_d = StFlush;
            StFlush: state_d = word_ok ? StRun : StErr;
            StRun:   if (load_mode) state_d = StLoad;
            StErr:   if (load_mode) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        byte_ready = 1'b0;
        cpu_rst    = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        unique case (state_q)
            StLoad: byte_ready = load_mode & ~full;
            StRun: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
            end
            StErr:   load_err = 1'b1;
            default: ;
        endcase
    end

    // Byte counter and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= accept;
            if (start_load) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + {{ADD_WIDTH{1'b0}}, 1'b1};
                addr_q  <= count_q[ADD_WIDTH-1:0];
                data_q  <= byte_in;
            end
        end
    end

    assign pm_wr_en     = wr_en_q;
    assign pm_addr      = addr_q;
    assign pm_wr_data   = data_q;
    assign bytes_loaded = count_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that sits directly upstream of the core's program memory write port. It accepts a stream of instruction bytes over a valid/ready handshake and writes them to consecutive program-memory addresses. It holds the core in reset while loading, then releases it once a whole number of 32-bit instructions has been stored. Partial-word or empty loads are flagged as errors.

## Interface
- `ADD_WIDTH`, default 7: program-memory byte address width; capacity is 2^ADD_WIDTH bytes.
- `DATA_WIDTH`, default 8: byte width of the stream and of program-memory writes.
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load_mode`, in, 1: 1 requests/continues a load, 0 ends it.
- `byte_valid`, in, 1: `byte_in` holds a byte.
- `byte_in`, in, DATA_WIDTH: instruction byte, little-endian within each word.
- `byte_ready`, out, 1: loader accepts a byte this cycle. A transfer occurs when `byte_valid & byte_ready`.
- `pm_wr_en`, out, 1: program-memory write strobe; drives the memory write enable.
- `pm_addr`, out, ADD_WIDTH: program-memory write address.
- `pm_wr_data`, out, DATA_WIDTH: program-memory write data.
- `cpu_rst`, out, 1: core reset, active-high.
- `load_done`, out, 1: last load completed cleanly and the core is running.
- `load_err`, out, 1: last load ended on a partial word, or with zero bytes.
- `bytes_loaded`, out, ADD_WIDTH+1: bytes accepted in the current or last load.

## Operation
- States:
  - IDLE: after reset.
  - LOAD
  - FLUSH
  - RUN
  - ERR
- Reset values:
  - State is IDLE.
  - `cpu_rst=1`.
  - `pm_wr_en=0`, `pm_addr=0`, `pm_wr_data=0`.
  - `load_done=0`, `load_err=0`, `bytes_loaded=0`.
- Entering LOAD:
  - From IDLE, RUN or ERR, `load_mode=1` moves to LOAD.
  - The address counter and `bytes_loaded` clear to 0; `load_done` and `load_err` clear.
  - `cpu_rst` is 1 in every state except RUN.
- `byte_ready` is combinational: `(state==LOAD) & load_mode & ~full`.
  - `full` means `bytes_loaded == 2^ADD_WIDTH`.
- Each accepted byte:
  - Registers the write: `pm_addr` takes the counter value and `pm_wr_data` takes `byte_in`.
  - Pulses `pm_wr_en` for exactly one cycle.
  - Increments the counter and `bytes_loaded`.
- The counter never wraps. At full, further bytes are back-pressured (`byte_ready=0`) and nothing is written.
- LOAD with `load_mode=0` goes to FLUSH. Bytes presented while `load_mode=0` are never accepted.
- FLUSH lasts one cycle so the final write lands. Then:
  - If `bytes_loaded[1:0]==0` and `bytes_loaded!=0`: go to RUN with `load_done=1` and `cpu_rst=0`.
  - Otherwise: go to ERR with `load_err=1`. `cpu_rst` stays 1.
- RUN and ERR hold until `load_mode=1` (or `rst`). In RUN, `cpu_rst` re-asserts in the same cycle LOAD is entered.
- `rst` mid-load aborts immediately to IDLE. Already-written memory contents are untouched.

## Timing
- Byte accepted at edge k: `pm_wr_en`, `pm_addr` and `pm_wr_data` are valid in the cycle after edge k. The memory captures the write at edge k+1.
- `load_mode` sampled 0 at edge k: FLUSH in cycle k, then RUN or ERR after edge k+1. `cpu_rst` falls after edge k+1.
- Sustained throughput is one byte per cycle with no bubbles.
- The last byte may be accepted in the same cycle `load_mode` is still 1. Its write completes during FLUSH, before `cpu_rst` falls.
- `load_mode` rising in RUN: LOAD after the next edge, and `cpu_rst=1` from that edge.

## Structure
- Shared package holds:
  - the state enum: IDLE, LOAD, FLUSH, RUN, ERR;
  - the program-memory byte address width constant shared with the memory and program counter.
- Implemented as a single module. The address/byte counter is inline; no sub-module is warranted.

## Test plan
- Clean load: send 8 bytes, then drop `load_mode`.
  - 8 single-cycle `pm_wr_en` pulses at addresses 0..7 with matching data.
  - `cpu_rst` falls 2 edges after the drop; `load_done=1`, `bytes_loaded=8`.
- Partial word: send 6 bytes, then drop `load_mode`.
  - ERR, `load_err=1`, `cpu_rst` stays 1.
  - A new load clears `load_err`.
- Empty load: `load_mode` pulsed for 1 cycle with no bytes.
  - ERR, `bytes_loaded=0`.
- Full memory: hold `byte_valid` for 130 cycles.
  - Exactly 128 writes at addresses 0..127; `byte_ready=0` from byte 128 onward.
  - After the drop: RUN, `bytes_loaded=128`.
- Back-pressure and gaps: random `byte_valid` gaps and 4 bytes 0x13,0x00,0x00,0x00.
  - Only handshaked bytes are written, in order.
  - The byte arriving with `load_mode=0` is ignored.
- Reload and reset: `load_mode=1` while in RUN, then `rst` after 3 bytes.
  - `cpu_rst` re-asserts on the next edge.
  - `rst` returns to IDLE with all outputs at reset values and no further writes.
